booth_mult_arbiter: RTL
=======================

Name: booth_mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one radix4_booth_multiplier instance between NUM_REQ requesters.
- Each requester raises a level request with stable signed operands. The arbiter grants one requester, latches its operands and pulses the multiplier start. It waits for the multiplier to finish, then returns the product tagged with the requester index.
- Sits between several producers (e.g. display/BCD pipelines, test stimulus) and the shared sequential multiplier datapath.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits, two's complement.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- CHECK_PARAM, 1, when 1: $fatal at elaboration if WIDTH==0, if NUM_REQ<2 or NUM_REQ>16, or if the radix4_booth_multiplier parameter checks fail.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; when low, FSM, pointer and multiplier hold their state.
- req  in  NUM_REQ  level request per requester; operands must stay stable while req is high.
- operand_a  in  NUM_REQ x WIDTH  signed multiplier operand per requester.
- operand_b  in  NUM_REQ x WIDTH  signed multiplicand operand per requester.
- grant  out  NUM_REQ  one-hot; high from latch cycle through the done cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; product and done_id are valid.
- done_id  out  clog2(NUM_REQ)  index of the requester that owns the product.
- product  out  2*WIDTH  signed product; held until the next done.

Behaviour:
- Reset values (async on rst_n low): state=IDLE, grant=0, busy=0, done=0, done_id=0, product=0, rr_ptr=0, operand registers=0.
- Multiplier contract (fixed): ready deasserts the cycle after start is sampled. It reasserts when the product is valid and stays high until the next start.
- FSM: IDLE -> START -> WAIT -> DONE -> IDLE. The FSM advances only when en=1.
  - IDLE: if any req bit is high, select the winner by round-robin search starting at rr_ptr, wrapping modulo NUM_REQ. Latch operand_a/operand_b[winner], set grant[winner], latch winner as done_id, set rr_ptr=(winner+1) mod NUM_REQ, go to START. If no req bit is high, stay in IDLE.
  - START: assert multiplier start for exactly one cycle; go to WAIT.
  - WAIT: ignore ready in the first WAIT cycle, since stale ready may still be high. From the second WAIT cycle on, ready==1 means: register the multiplier product into product and go to DONE.
  - DONE: done=1 for one cycle; grant clears at the end of this cycle; go to IDLE.
- Latency: req sampled in IDLE at edge k gives the start pulse in cycle k+1 and done in cycle k+3+L. L is the multiplier compute time (WIDTH/2 + its fixed overhead).
  - Minimum request-to-request spacing for the same requester is one IDLE cycle after DONE.
- Arbitration rules:
  - Only one operation is in flight.
  - Requests arriving during busy wait; they are never lost while held.
  - With all requesters active, the grant order is fair rotation 0,1,...,NUM_REQ-1,0,...
- Dropped request: if req[granted] falls mid-operation, the operation still completes and done still fires. The requester ignores the result.
  - Operands are taken from the latched copy, so input changes after the latch have no effect.
- en low: all registers hold, including a pending done (done stays asserted until en returns and DONE completes). en is driven straight to the multiplier en input.
- Reset mid-operation: everything returns to reset values immediately and no done is produced. The multiplier shares rst_n.
- Width rules:
  - Operands are signed two's complement.
  - The product is the full 2*WIDTH result with no truncation.
  - The most-negative operand squared, -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2), must be exact.
- Simultaneous events: a new req in the same cycle as DONE is not granted until the IDLE cycle that follows.

Decomposition:
- Shared package booth_arbiter_pkg holds:
  - state_t enum {IDLE, START, WAIT, DONE};
  - function rr_select(req, ptr) returning the winner index and a valid flag;
  - localparam helper for the ID width, clog2(NUM_REQ), minimum 1.
- One sub-module: rr_arbiter (combinational round-robin priority select from req and rr_ptr).
- The existing radix4_booth_multiplier is instantiated unchanged.

Test Plan:
- WIDTH=8, req[2] alone with a=3, b=5 -> grant=0100, one start pulse, done with done_id=2, product=0x000F, busy low one cycle after done.
- req[1] with a=-7, b=6 -> product=0xFFD6 (-42); req[0] with a=-128, b=-128 -> product=0x4000 (16384).
- All four req held high with distinct operands -> done_id sequence 0,1,2,3,0, each product correct, exactly one grant bit high at any time.
- req[3] dropped and operand_a[3] changed in the WAIT state -> done still pulses with done_id=3 and the product of the originally latched operands.
- en held low for 5 cycles during WAIT -> no state change, done delayed by exactly 5 cycles, same product.
- rst_n pulsed low during WAIT -> all outputs return to reset values asynchronously, no done; a fresh request afterwards completes normally, with rr_ptr restarting at 0.

Source files
------------

// File: rtl/booth_arbiter_pkg.sv
// Shared types and helpers for the booth multiplier arbiter: FSM state
// encoding, requester-ID width helper and the round-robin search function.
package booth_arbiter_pkg;

    localparam int MAX_REQ  = 16;
    localparam int MAX_ID_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] idx;
    } rr_result_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set request at or after ptr, wrapping modulo n.
    function automatic rr_result_t rr_select(
        input logic [MAX_REQ-1:0]  req,
        input logic [MAX_ID_W-1:0] ptr,
        input int                  n
    );
        rr_result_t res;
        int         pos;
        res = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            pos = (int'(ptr) + i) % n;
            if (i < n && !res.valid && req[pos[MAX_ID_W-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = pos[MAX_ID_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// Combinational round-robin select: lowest set request at or after ptr.
module rr_arbiter
    import booth_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    logic [MAX_REQ-1:0]  req_ext;
    logic [MAX_ID_W-1:0] ptr_ext;
    rr_result_t          sel;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_REQ; gi++) begin : g_req_ext
            if (gi < NUM_REQ) begin : g_used
                assign req_ext[gi] = req[gi];
            end else begin : g_pad
                assign req_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign ptr_ext = MAX_ID_W'(ptr);
    assign sel     = rr_select(req_ext, ptr_ext, NUM_REQ);
    assign valid   = sel.valid;
    assign winner  = ID_W'(sel.idx);

endmodule

// File: rtl/radix4_booth_multiplier.sv
// Sequential signed radix-4 Booth multiplier. One Booth digit per cycle;
// ready drops after start and returns once the product register is valid.
module radix4_booth_multiplier #(
    parameter int WIDTH       = 8,
    parameter int CHECK_PARAM = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ready
);

    // Odd widths are sign-extended by one bit so digits pair up evenly.
    localparam int WE    = WIDTH + (WIDTH % 2);
    localparam int NSTEP = WE / 2;
    localparam int AW    = 2 * WE;
    localparam int CW    = $clog2(NSTEP + 1);

    generate
        if (CHECK_PARAM != 0) begin : g_check
            if (WIDTH < 1) begin : g_bad_width
                $fatal(1, "radix4_booth_multiplier: WIDTH must be at least 1");
            end
        end
    endgenerate

    logic [AW-1:0]        acc_reg;
    logic [AW-1:0]        mcand_reg;
    logic [AW-1:0]        pp;
    logic [WE:0]          mplr_reg;
    logic [CW-1:0]        cnt_reg;
    logic                 ready_reg;
    logic [2*WIDTH-1:0]   product_reg;

    // Partial product selected by the current overlapping 3-bit Booth group.
    always_comb begin
        pp = '0;
        case (mplr_reg[2:0])
            3'b001, 3'b010: pp = mcand_reg;
            3'b011:         pp = mcand_reg << 1;
            3'b100:         pp = -(mcand_reg << 1);
            3'b101, 3'b110: pp = -mcand_reg;
            default:        pp = '0;
        endcase
    end

    // Load on start, accumulate one digit per cycle, then publish the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplr_reg    <= '0;
            cnt_reg     <= '0;
            ready_reg   <= 1'b1;
            product_reg <= '0;
        end else if (en) begin
            if (start) begin
                acc_reg   <= '0;
                mcand_reg <= AW'($signed(multiplicand));
                mplr_reg  <= {WE'($signed(multiplier)), 1'b0};
                cnt_reg   <= CW'(NSTEP);
                ready_reg <= 1'b0;
            end else if (!ready_reg) begin
                if (cnt_reg != '0) begin
                    acc_reg   <= acc_reg + pp;
                    mcand_reg <= mcand_reg << 2;
                    mplr_reg  <= {{2{mplr_reg[WE]}}, mplr_reg[WE:2]};
                    cnt_reg   <= cnt_reg - CW'(1);
                end else begin
                    product_reg <= (2*WIDTH)'(acc_reg);
                    ready_reg   <= 1'b1;
                end
            end
        end
    end

    assign product = product_reg;
    assign ready   = ready_reg;

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin sequencer sharing one Booth multiplier among NUM_REQ requesters.
// One operation in flight: grant, latch operands, start, wait, return tagged product.
module booth_mult_arbiter
    import booth_arbiter_pkg::*;
#(
    parameter  int WIDTH       = 8,
    parameter  int NUM_REQ     = 4,
    parameter  int CHECK_PARAM = 1,
    localparam int ID_W        = id_width(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   operand_a,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   operand_b,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy,
    output logic                            done,
    output logic [ID_W-1:0]                 done_id,
    output logic [2*WIDTH-1:0]              product
);

    generate
        if (CHECK_PARAM != 0) begin : g_check
            if (WIDTH < 1 || NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_param
                $fatal(1, "booth_mult_arbiter: illegal WIDTH or NUM_REQ");
            end
        end
    endgenerate

    state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [ID_W-1:0]      id_reg, id_next;
    logic [ID_W-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [2*WIDTH-1:0]   product_reg, product_next;
    logic [WIDTH-1:0]     op_a_reg, op_a_next;
    logic [WIDTH-1:0]     op_b_reg, op_b_next;
    logic                 wait_first_reg, wait_first_next;

    logic [ID_W-1:0]      arb_winner;
    logic                 arb_valid;
    logic                 mult_start;
    logic                 mult_ready;
    logic [2*WIDTH-1:0]   mult_product;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req    (req),
        .ptr    (rr_ptr_reg),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    radix4_booth_multiplier #(
        .WIDTH       (WIDTH),
        .CHECK_PARAM (CHECK_PARAM)
    ) u_mult (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .start        (mult_start),
        .multiplier   (op_a_reg),
        .multiplicand (op_b_reg),
        .product      (mult_product),
        .ready        (mult_ready)
    );

    assign mult_start = (state_reg == START);

    // Next-state and datapath updates; everything holds while en is low.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        id_next         = id_reg;
        rr_ptr_next     = rr_ptr_reg;
        product_next    = product_reg;
        op_a_next       = op_a_reg;
        op_b_next       = op_b_reg;
        wait_first_next = wait_first_reg;
        if (en) begin
            case (state_reg)
                IDLE: begin
                    if (arb_valid) begin
                        op_a_next   = operand_a[arb_winner];
                        op_b_next   = operand_b[arb_winner];
                        grant_next  = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_winner;
                        id_next     = arb_winner;
                        rr_ptr_next = (arb_winner == ID_W'(NUM_REQ-1)) ? '0
                                                                        : arb_winner + ID_W'(1);
                        state_next  = START;
                    end
                end
                START: begin
                    wait_first_next = 1'b1;
                    state_next      = WAIT;
                end
                WAIT: begin
                    // ready may still be stale on the first WAIT cycle.
                    wait_first_next = 1'b0;
                    if (!wait_first_reg && mult_ready) begin
                        product_next = mult_product;
                        state_next   = DONE;
                    end
                end
                DONE: begin
                    grant_next = '0;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            id_reg         <= '0;
            rr_ptr_reg     <= '0;
            product_reg    <= '0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            wait_first_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            id_reg         <= id_next;
            rr_ptr_reg     <= rr_ptr_next;
            product_reg    <= product_next;
            op_a_reg       <= op_a_next;
            op_b_reg       <= op_b_next;
            wait_first_reg <= wait_first_next;
        end
    end

    assign grant   = grant_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign done_id = id_reg;
    assign product = product_reg;

endmodule
